// File: rtl/bitdepext_seq_pkg.sv
// Shared definitions for the iterative bit-extract / bit-deposit unit.
// Holds the op encodings, the controller state enum and the datapath width.
package bitdepext_seq_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic OP_BEXT = 1'b0;
    localparam logic OP_BDEP = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitdepext_seq.sv
// Iterative gather (bext) / scatter (bdep) unit: scans one mask bit per cycle, LSB first,
// and finishes early once no set mask bits remain above the cursor.
module bitdepext_seq
    import bitdepext_seq_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd
);

    state_e          state;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] result;
    logic            op_q;
    logic [4:0]      i;
    logic [5:0]      k;

    logic            rest_zero;
    logic            last_bit;
    logic [XLEN-1:0] result_nxt;

    // k <= i at every step, so k[4:0] is always a legal bit index while scanning.
    always_comb begin
        rest_zero  = ((mask >> i) >> 1) == '0;
        last_bit   = rest_zero || (i == 5'd31);
        result_nxt = result;
        if (mask[i]) begin
            if (op_q == OP_BEXT) begin
                result_nxt[k[4:0]] = data[i];
            end else begin
                result_nxt[i] = data[k[4:0]];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rd        <= '0;
            data      <= '0;
            mask      <= '0;
            result    <= '0;
            op_q      <= OP_BEXT;
            i         <= '0;
            k         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data     <= rs1;
                        mask     <= rs2;
                        op_q     <= op;
                        result   <= '0;
                        i        <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    result <= result_nxt;
                    if (mask[i]) begin
                        k <= k + 6'd1;
                    end
                    if (last_bit) begin
                        rd        <= result_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        i <= i + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
